// File: rtl/shift_reg_digit_scanner_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared constants and types for the multiplexed digit scanner that feeds the
// 74HC595 shift-out stage.
//   FRAME_SIZE      : width of one frame handed to the shift-out stage
//   SEG_W / SEL_W   : segment field and digit-select field widths
//   SEG_LSB/SEL_LSB : field offsets inside the frame
//   MIN_REFRESH_DIV : shortest digit period that still lets a 16-bit shift
//                     plus latch finish before the next frame
//   scan_state_e    : scanner FSM states
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    localparam int unsigned FRAME_SIZE      = 16;
    localparam int unsigned SEG_W           = 8;
    localparam int unsigned SEL_W           = 8;
    localparam int unsigned MIN_REFRESH_DIV = 40;
    localparam int unsigned SEG_LSB         = 0;
    localparam int unsigned SEL_LSB         = 8;

    typedef enum logic [0:0] {
        IDLE_COUNT,
        EMIT
    } scan_state_e;

    // Digit period actually used: short requested periods are stretched to
    // the minimum so a frame is never overwritten mid-shift.
    function automatic int unsigned eff_div(input int unsigned div);
        return (div < MIN_REFRESH_DIV) ? MIN_REFRESH_DIV : div;
    endfunction

endpackage

// File: rtl/shift_reg_digit_scanner_if.sv
// -----------------------------------------------------------------------------
// shift_reg_digit_scanner_if
// Host-side write port and frame output of the digit scanner.
//   i_wr_en         : write strobe for the digit bank
//   i_wr_addr[2:0]  : digit index to write
//   i_wr_data[7:0]  : segment pattern (bit0=a .. bit6=g, bit7=dp)
//   i_blank         : level; forces emitted frames to zero
//   o_value[15:0]   : frame, [7:0] segments, [15:8] one-hot digit select
//   o_enable_toggle : flips once per new frame
//   o_digit_idx[2:0]: digit index of the most recent frame
//   o_frame_strobe  : one-cycle pulse with each toggle
// Modports: master (host side), slave (scanner side).
// -----------------------------------------------------------------------------
interface shift_reg_digit_scanner_if;
    import shift_reg_pkg::*;

    logic                  i_wr_en;
    logic [2:0]            i_wr_addr;
    logic [SEG_W-1:0]      i_wr_data;
    logic                  i_blank;
    logic [FRAME_SIZE-1:0] o_value;
    logic                  o_enable_toggle;
    logic [2:0]            o_digit_idx;
    logic                  o_frame_strobe;

    modport master (
        output i_wr_en,
        output i_wr_addr,
        output i_wr_data,
        output i_blank,
        input  o_value,
        input  o_enable_toggle,
        input  o_digit_idx,
        input  o_frame_strobe
    );

    modport slave (
        input  i_wr_en,
        input  i_wr_addr,
        input  i_wr_data,
        input  i_blank,
        output o_value,
        output o_enable_toggle,
        output o_digit_idx,
        output o_frame_strobe
    );

endinterface

// File: rtl/shift_reg_digit_scanner_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to 7-segment decoder, common-cathode (1 = lit).
//   i_hex[3:0] : value 0..F
//   o_seg[6:0] : segments, bit0=a .. bit6=g
// -----------------------------------------------------------------------------
module hex_to_seg7 (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        unique case (i_hex)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
        endcase
    end

endmodule

// File: rtl/shift_reg_digit_scanner.sv
// -----------------------------------------------------------------------------
// shift_reg_digit_scanner
// Multiplexed display scanner in front of the 74HC595 shift-out stage. Holds
// one segment pattern per digit; every EFF_DIV clocks it emits the frame for
// the next digit and flips o_enable_toggle so the shift-out stage picks it up.
//
// Parameters:
//   NUM_DIGITS  : number of multiplexed digits, 1..8
//   REFRESH_DIV : clocks per digit step, clamped to at least 40
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous, active-high reset
//   bus     : shift_reg_digit_scanner_if.slave (write port + frame output)
// Build option:
//   SHIFT_REG_SEG_DECODE_EN : when defined, i_wr_data[3:0] is a hex nibble
//   decoded to segments at write time and i_wr_data[4] is dp; otherwise
//   i_wr_data is stored raw.
// -----------------------------------------------------------------------------
module shift_reg_digit_scanner
    import shift_reg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 16000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    shift_reg_digit_scanner_if.slave  bus
);

    localparam int unsigned     EFF_DIV  = eff_div(REFRESH_DIV);
    localparam int unsigned     CNT_W    = $clog2(EFF_DIV);
    // EMIT is entered one count early so the EMIT cycle itself is terminal.
    localparam logic [CNT_W-1:0] PRE_TC  = CNT_W'(EFF_DIV - 2);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("NUM_DIGITS must be in 1..8");
    end

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            scan_q, scan_d;
    logic [FRAME_SIZE-1:0] value_q, value_d;
    logic [2:0]            idx_q, idx_d;
    logic                  tog_q, tog_d;
    logic                  strobe_q, strobe_d;

    // Full 8-entry bank keeps the 3-bit index exact; entries at or above
    // NUM_DIGITS are never written and stay zero.
    logic [7:0][SEG_W-1:0] digit_q;

    logic [SEG_W-1:0]      wr_pattern;
    logic                  wr_hit;
    logic [SEL_W-1:0]      sel;
    logic [FRAME_SIZE-1:0] frame;

    // ---------------------------------------------------------------------
    // Write path
    // ---------------------------------------------------------------------
`ifdef SHIFT_REG_SEG_DECODE_EN
    logic [6:0] dec_seg;

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex (bus.i_wr_data[3:0]),
        .o_seg (dec_seg)
    );

    assign wr_pattern = {bus.i_wr_data[4], dec_seg};
`else
    assign wr_pattern = bus.i_wr_data;
`endif

    assign wr_hit = bus.i_wr_en && (32'(bus.i_wr_addr) < NUM_DIGITS);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            digit_q <= '0;
        end else if (wr_hit) begin
            digit_q[bus.i_wr_addr] <= wr_pattern;
        end
    end

    // ---------------------------------------------------------------------
    // Frame build: reads the bank before any same-cycle write lands
    // ---------------------------------------------------------------------
    always_comb begin
        sel   = SEL_W'(1) << scan_q;
        frame = '0;
        frame[SEG_LSB +: SEG_W] = digit_q[scan_q];
        frame[SEL_LSB +: SEL_W] = sel;
    end

    // ---------------------------------------------------------------------
    // Scan FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        scan_d   = scan_q;
        value_d  = value_q;
        idx_d    = idx_q;
        tog_d    = tog_q;
        strobe_d = 1'b0;
        unique case (state_q)
            IDLE_COUNT: begin
                if (cnt_q == PRE_TC) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d  = IDLE_COUNT;
                cnt_d    = '0;
                value_d  = bus.i_blank ? '0 : frame;
                tog_d    = ~tog_q;
                strobe_d = 1'b1;
                idx_d    = scan_q;
                scan_d   = (scan_q == LAST_IDX) ? 3'd0 : scan_q + 3'd1;
            end
            default: state_d = IDLE_COUNT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE_COUNT;
            cnt_q    <= '0;
            scan_q   <= '0;
            value_q  <= '0;
            idx_q    <= '0;
            tog_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scan_q   <= scan_d;
            value_q  <= value_d;
            idx_q    <= idx_d;
            tog_q    <= tog_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.o_value         = value_q;
    assign bus.o_enable_toggle = tog_q;
    assign bus.o_digit_idx     = idx_q;
    assign bus.o_frame_strobe  = strobe_q;

endmodule

// File: tb/tb_shift_reg_digit_scanner.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_digit_scanner
// Scoreboard bench. Main DUT: NUM_DIGITS=4, REFRESH_DIV=100. Second DUT:
// NUM_DIGITS=1, REFRESH_DIV=10 (clamped to 40). Expected frames (cycle of
// arrival, value, digit index) are queued as stimulus is issued; a monitor
// pops and compares on every frame strobe. Write data is chosen so the same
// expected segments result with or without SHIFT_REG_SEG_DECODE_EN.
// -----------------------------------------------------------------------------
module tb_shift_reg_digit_scanner;

`ifdef SHIFT_REG_SEG_DECODE_EN
    localparam logic [7:0] D0 = 8'h00;  // -> 3F
    localparam logic [7:0] D1 = 8'h18;  // -> FF
    localparam logic [7:0] D2 = 8'h02;  // -> 5B
    localparam logic [7:0] D3 = 8'h0A;  // -> 77
`else
    localparam logic [7:0] D0 = 8'h3F;
    localparam logic [7:0] D1 = 8'hFF;
    localparam logic [7:0] D2 = 8'h5B;
    localparam logic [7:0] D3 = 8'h77;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] val;
        logic [2:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    shift_reg_digit_scanner_if bus ();
    shift_reg_digit_scanner_if bus2 ();

    shift_reg_digit_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (100)
    ) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    shift_reg_digit_scanner #(
        .NUM_DIGITS  (1),
        .REFRESH_DIV (10)
    ) u_dut_small (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus2)
    );

    initial forever #5 clk = ~clk;

    // Count of non-reset edges since the last reset release.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
        step();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic push(input int c, input logic [15:0] v, input logic [2:0] i);
        exp_t e;
        e.cyc = 32'(c);
        e.val = v;
        e.idx = i;
        sb.push_back(e);
    endtask

    // Main monitor
    logic prev_tog;
    logic exp_tog;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_tog  = 1'b0;
            prev_tog = bus.o_enable_toggle;
        end else begin
            if (bus.o_frame_strobe || (bus.o_enable_toggle != prev_tog))
                check("strobe_vs_toggle", 32'(bus.o_frame_strobe),
                      32'(bus.o_enable_toggle != prev_tog));
            if (bus.o_frame_strobe) begin
                exp_tog = ~exp_tog;
                check("toggle_level", 32'(bus.o_enable_toggle), 32'(exp_tog));
                if (sb.size() == 0) begin
                    check("unexpected_frame", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("frame_cycle", 32'(cyc), e.cyc);
                    check("frame_value", 32'(bus.o_value), 32'(e.val));
                    check("frame_idx", 32'(bus.o_digit_idx), 32'(e.idx));
                end
            end
            prev_tog = bus.o_enable_toggle;
        end
    end

    // Single-digit, clamped-period monitor
    int last2;
    always @(negedge clk) begin
        if (rst) begin
            last2 = 0;
        end else if (bus2.o_frame_strobe) begin
            check("clamp_spacing", 32'(cyc - last2), 32'd40);
            check("single_digit_value", 32'(bus2.o_value), 32'h0100);
            check("single_digit_idx", 32'(bus2.o_digit_idx), 32'd0);
            last2 = cyc;
        end
    end

    initial begin
        bus.i_wr_en    = 1'b0;
        bus.i_wr_addr  = 3'd0;
        bus.i_wr_data  = 8'h00;
        bus.i_blank    = 1'b0;
        bus2.i_wr_en   = 1'b0;
        bus2.i_wr_addr = 3'd0;
        bus2.i_wr_data = 8'h00;
        bus2.i_blank   = 1'b0;

        repeat (3) step();
        check("reset_value", 32'(bus.o_value), 32'h0);
        check("reset_toggle", 32'(bus.o_enable_toggle), 32'h0);
        check("reset_idx", 32'(bus.o_digit_idx), 32'h0);
        check("reset_strobe", 32'(bus.o_frame_strobe), 32'h0);
        rst = 1'b0;

        // Empty bank: select walks 1,2,4,8 and wraps
        push(100, 16'h0100, 3'd0);
        push(200, 16'h0200, 3'd1);
        push(300, 16'h0400, 3'd2);
        push(400, 16'h0800, 3'd3);
        push(500, 16'h0100, 3'd0);

        wait_to(510);
        write(3'd0, D0);
        wait_to(520);
        write(3'd2, D2);
        push(600, 16'h0200, 3'd1);
        push(700, 16'h045B, 3'd2);
        push(800, 16'h0800, 3'd3);
        push(900, 16'h013F, 3'd0);

        // Write to digit 1 in the very cycle digit 1 is emitted
        wait_to(999);
        push(1000, 16'h0200, 3'd1);
        push(1100, 16'h045B, 3'd2);
        push(1200, 16'h0800, 3'd3);
        push(1300, 16'h013F, 3'd0);
        push(1400, 16'h02FF, 3'd1);
        write(3'd1, D1);

        wait_to(1450);
        bus.i_blank = 1'b1;
        push(1500, 16'h0000, 3'd2);
        push(1600, 16'h0800, 3'd3);
        push(1700, 16'h013F, 3'd0);
        wait_to(1550);
        bus.i_blank = 1'b0;

        // Out-of-range address is dropped; digit 3 gets a pattern
        wait_to(1710);
        write(3'd5, 8'hAA);
        wait_to(1720);
        write(3'd3, D3);
        push(1800, 16'h02FF, 3'd1);
        push(1900, 16'h045B, 3'd2);
        push(2000, 16'h0877, 3'd3);

        wait_to(2050);
        check("frames_before_reset", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        step();
        step();
        check("midreset_value", 32'(bus.o_value), 32'h0);
        check("midreset_toggle", 32'(bus.o_enable_toggle), 32'h0);
        check("midreset_idx", 32'(bus.o_digit_idx), 32'h0);
        step();
        rst = 1'b0;
        // Bank cleared, scan restarts at digit 0
        push(100, 16'h0100, 3'd0);
        push(200, 16'h0200, 3'd1);
        wait_to(250);
        check("frames_after_reset", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
